ir_tx_ctrl: RTL
===============

Name: ir_tx_ctrl

Overview:
Bus-mapped IR transmitter controller with three parts:
- A command register whose source is either the bus or the push buttons.
- A programmable packet-rate timer plus a one-shot trigger.
- A packet encoder that drives a carrier-modulated IR_LED.

It replaces the fixed 4-bit, fixed-10 Hz transmitter top. Command width, bus base address, carrier frequency, packet timing and repeat period are all parameters. It adds bus readback, software enable and one-shot send, and status/packet counting.

Parameters:
- CMD_W, 4: command bits per packet (1..8).
- BASE_ADDR, 8'h90: register block base address; occupies BASE_ADDR..BASE_ADDR+2.
- CARRIER_HALF, 1389: CLK cycles per carrier half-period (36 kHz at 100 MHz).
- START_PULSES, 88: carrier periods in the start burst.
- SEL_PULSES, 22: carrier periods in the car-select burst.
- GAP_PULSES, 40: carrier periods in every gap.
- ASSERT_PULSES, 44: burst length for a command bit = 1.
- DEASSERT_PULSES, 22: burst length for a command bit = 0.
- PERIOD_CYC, 10_000_000: CLK cycles between auto packets (10 Hz).

Ports:
- CLK  in  1  system clock.
- RESET  in  1  synchronous, active-high reset.
- SRC_BUTTONS  in  1  1: command comes from PUSH_BUTTON; 0: command comes from the bus register.
- PUSH_BUTTON  in  CMD_W  button command.
- BUS_ADDR  in  8  bus address.
- BUS_DATA_IN  in  8  bus write data.
- BUS_WE  in  1  bus write enable.
- BUS_DATA_OUT  out  8  read data.
- BUS_DATA_OE  out  1  read-data valid / tristate enable.
- IR_LED  out  1  modulated IR output.
- BUSY  out  1  packet in progress.
- PKT_DONE  out  1  one-cycle pulse at packet end.

Behaviour:
- Register map, clocked on CLK:
  - BASE+0 CMD (R/W): [CMD_W-1:0].
    - When SRC_BUTTONS=1, the register loads PUSH_BUTTON every cycle and bus writes are ignored.
    - A read returns the register value; unused bits read 0.
  - BASE+1 CTRL: bit0 AUTO_EN (R/W); bit1 ONESHOT (write-1 strobe, always reads 0).
  - BASE+2 STATUS (RO): bit0 BUSY; [7:1] TX_COUNT, 7-bit count of completed packets, wraps 127→0.
- Read: BUS_WE=0 with an address in range → BUS_DATA_OUT and BUS_DATA_OE=1 on the next cycle, for exactly one cycle. Otherwise BUS_DATA_OUT=0 and OE=0.
- Rate timer:
  - While AUTO_EN=1, counts 0..PERIOD_CYC-1.
  - Tick when count = PERIOD_CYC-1, then wraps to 0.
  - AUTO_EN=0 holds the counter at 0. The first tick comes PERIOD_CYC cycles after enable.
- Trigger = tick OR ONESHOT write.
  - Two triggers in the same cycle start one packet.
  - A trigger while BUSY is dropped; no queueing.
- Packet start (trigger while IDLE):
  - Latch the CMD register into a shadow register. A same-cycle CMD write is not seen; later writes do not affect the running packet.
  - Reset the carrier counter; BUSY=1 from the next cycle.
- Carrier: square wave, CARRIER_HALF cycles high then CARRIER_HALF cycles low. Pulse counters advance once per completed carrier period.
- FSM: IDLE → START_BURST → START_GAP → SEL_BURST → SEL_GAP → {BIT_BURST → BIT_GAP} × CMD_W → IDLE.
  - Bits are sent MSB first.
  - Burst length per bit: ASSERT_PULSES if the bit is 1, DEASSERT_PULSES if 0.
- IR_LED = carrier AND (state is a *_BURST state); output is registered and glitch-free. IR_LED=0 in all gaps and in IDLE.
- Packet end: after the last BIT_GAP, PKT_DONE pulses for one cycle, TX_COUNT increments, and BUSY=0 in the same cycle the state returns to IDLE.
- Reset (including mid-packet), same edge:
  - State IDLE.
  - IR_LED, BUSY, PKT_DONE, BUS_DATA_OE, BUS_DATA_OUT = 0.
  - CMD, AUTO_EN, TX_COUNT, timer = 0.
- Packet length in CLK cycles = 2·CARRIER_HALF·(START + SEL + 2·GAP + Σbursts + CMD_W·GAP).

Decomposition:
- Package ir_tx_pkg holds:
  - The FSM state enum.
  - Register offset constants (CMD=0, CTRL=1, STATUS=2).
  - CTRL bit indices.
- One natural sub-module: ir_packet_encoder. It contains the FSM, carrier generator and pulse counters, and has inputs CLK, RESET, START, CMD and outputs IR_LED, BUSY, DONE.
- Register file and rate timer stay in ir_tx_ctrl.

Test Plan:
Bench parameters: CARRIER_HALF=2, START=4, SEL=3, GAP=2, ASSERT=2, DEASSERT=1, CMD_W=4, PERIOD_CYC=400.
1. Write CMD=4'b0101, then ONESHOT → BUSY high for 100 cycles; 13 IR_LED rising edges; burst lengths 4,3,1,2,1,2 carrier periods (MSB first); PKT_DONE pulse; STATUS reads 8'h02.
2. Write AUTO_EN=1 with CMD=0 → first packet starts 400 cycles after enable, 92 cycles long; next packet starts 400 cycles after the first; AUTO_EN=0 stops further packets.
3. Mid-packet: write CMD=4'b1111, then ONESHOT while BUSY → current packet keeps the old command; the ONESHOT is dropped; the next ONESHOT sends 108 cycles with 15 edges.
4. SRC_BUTTONS=1, PUSH_BUTTON=4'b1010, bus write CMD=4'h3 → read of BASE+0 returns 8'h0A; packet uses 1010.
5. Assert RESET for 1 cycle during SEL_BURST → IR_LED=0 and BUSY=0 after that edge; STATUS reads 0; a new ONESHOT sends a complete packet.
6. Read BASE+3 and BASE-1 → BUS_DATA_OE stays 0. Send 128 packets → TX_COUNT wraps to 0.

Source files
------------

// File: rtl/ir_tx_pkg.sv
// ---------------------------------------------------------------------------
// ir_tx_pkg
// Shared definitions for the IR transmitter controller:
//   - ir_state_t      : packet encoder FSM states
//   - REG_*           : register offsets relative to the block base address
//   - CTRL_*          : bit positions inside the CTRL register
//   - is_burst_state  : true for states in which the carrier reaches the LED
// ---------------------------------------------------------------------------
package ir_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START_BURST,
    ST_START_GAP,
    ST_SEL_BURST,
    ST_SEL_GAP,
    ST_BIT_BURST,
    ST_BIT_GAP
  } ir_state_t;

  localparam logic [7:0] REG_CMD    = 8'd0;
  localparam logic [7:0] REG_CTRL   = 8'd1;
  localparam logic [7:0] REG_STATUS = 8'd2;

  localparam int CTRL_AUTO_EN = 0;
  localparam int CTRL_ONESHOT = 1;

  function automatic logic is_burst_state(input ir_state_t s);
    return (s == ST_START_BURST) || (s == ST_SEL_BURST) || (s == ST_BIT_BURST);
  endfunction

endpackage

// File: rtl/ir_packet_encoder.sv
// ---------------------------------------------------------------------------
// ir_packet_encoder
// Sends one IR packet per accepted START: start burst, gap, car-select burst,
// gap, then CMD_W bit bursts (MSB first) each followed by a gap. Every segment
// is a whole number of carrier periods.
// Ports:
//   CLK     in   system clock
//   RESET   in   synchronous active-high reset
//   START   in   begin a packet (ignored unless idle)
//   CMD     in   command word, captured when a packet starts
//   IR_LED  out  registered carrier-modulated output
//   BUSY    out  packet in progress
//   DONE    out  one-cycle pulse in the first idle cycle after a packet
// ---------------------------------------------------------------------------
module ir_packet_encoder
  import ir_tx_pkg::*;
#(
  parameter int CMD_W           = 4,
  parameter int CARRIER_HALF    = 1389,
  parameter int START_PULSES    = 88,
  parameter int SEL_PULSES      = 22,
  parameter int GAP_PULSES      = 40,
  parameter int ASSERT_PULSES   = 44,
  parameter int DEASSERT_PULSES = 22
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [CMD_W-1:0] CMD,
  output logic             IR_LED,
  output logic             BUSY,
  output logic             DONE
);

  localparam int CAR_PERIOD = 2 * CARRIER_HALF;
  localparam int CAR_W      = (CAR_PERIOD > 2) ? $clog2(CAR_PERIOD) : 1;
  localparam int PULSE_W    = 16;
  localparam int BIT_W      = (CMD_W > 1) ? $clog2(CMD_W) : 1;

  ir_state_t          state, state_nxt;
  logic [CAR_W-1:0]   car_cnt;
  logic [PULSE_W-1:0] pulse_cnt;
  logic [PULSE_W-1:0] seg_len;
  logic [BIT_W-1:0]   bit_idx;
  logic [CMD_W-1:0]   shadow;
  logic               period_end;
  logic               seg_end;
  logic               last_bit;

  // Segment length for the current state; a segment ends on the carrier
  // period boundary that completes its last pulse.
  always_comb begin
    period_end = (car_cnt == CAR_W'(CAR_PERIOD - 1));
    last_bit   = (bit_idx == '0);
    seg_len    = PULSE_W'(GAP_PULSES);
    case (state)
      ST_START_BURST: seg_len = PULSE_W'(START_PULSES);
      ST_SEL_BURST:   seg_len = PULSE_W'(SEL_PULSES);
      ST_BIT_BURST:   seg_len = shadow[bit_idx] ? PULSE_W'(ASSERT_PULSES)
                                                : PULSE_W'(DEASSERT_PULSES);
      default:        seg_len = PULSE_W'(GAP_PULSES);
    endcase
    seg_end = period_end && (pulse_cnt == seg_len - PULSE_W'(1));
  end

  // Next-state logic for the packet sequence.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:        if (START)   state_nxt = ST_START_BURST;
      ST_START_BURST: if (seg_end) state_nxt = ST_START_GAP;
      ST_START_GAP:   if (seg_end) state_nxt = ST_SEL_BURST;
      ST_SEL_BURST:   if (seg_end) state_nxt = ST_SEL_GAP;
      ST_SEL_GAP:     if (seg_end) state_nxt = ST_BIT_BURST;
      ST_BIT_BURST:   if (seg_end) state_nxt = ST_BIT_GAP;
      ST_BIT_GAP:     if (seg_end) state_nxt = last_bit ? ST_IDLE : ST_BIT_BURST;
      default:        state_nxt = ST_IDLE;
    endcase
  end

  // State register plus the registered LED and end-of-packet pulse.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state  <= ST_IDLE;
      IR_LED <= 1'b0;
      DONE   <= 1'b0;
    end else begin
      state  <= state_nxt;
      IR_LED <= is_burst_state(state) && (car_cnt < CAR_W'(CARRIER_HALF));
      DONE   <= (state == ST_BIT_GAP) && seg_end && last_bit;
    end
  end

  // Carrier phase, pulse count and bit pointer. The carrier restarts with
  // each packet so every burst begins on a full high half-period.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      car_cnt   <= '0;
      pulse_cnt <= '0;
      bit_idx   <= '0;
      shadow    <= '0;
    end else if (state == ST_IDLE) begin
      car_cnt   <= '0;
      pulse_cnt <= '0;
      if (START) begin
        shadow  <= CMD;
        bit_idx <= BIT_W'(CMD_W - 1);
      end
    end else begin
      car_cnt <= period_end ? '0 : car_cnt + CAR_W'(1);
      if (period_end)
        pulse_cnt <= seg_end ? '0 : pulse_cnt + PULSE_W'(1);
      if ((state == ST_BIT_GAP) && seg_end && !last_bit)
        bit_idx <= bit_idx - BIT_W'(1);
    end
  end

  assign BUSY = (state != ST_IDLE);

endmodule

// File: rtl/ir_tx_ctrl.sv
// ---------------------------------------------------------------------------
// ir_tx_ctrl
// Bus-mapped IR transmitter: command/control/status registers, packet-rate
// timer with one-shot trigger, and the packet encoder.
// Ports:
//   CLK          in   system clock
//   RESET        in   synchronous active-high reset
//   SRC_BUTTONS  in   1: CMD follows PUSH_BUTTON, 0: CMD is bus-written
//   PUSH_BUTTON  in   button command
//   BUS_ADDR     in   bus address
//   BUS_DATA_IN  in   bus write data
//   BUS_WE       in   bus write enable
//   BUS_DATA_OUT out  read data (one cycle after the read request)
//   BUS_DATA_OE  out  read data valid
//   IR_LED       out  modulated IR output
//   BUSY         out  packet in progress
//   PKT_DONE     out  one-cycle pulse at packet end
// Registers: BASE+0 CMD, BASE+1 CTRL {ONESHOT, AUTO_EN}, BASE+2 STATUS
// {TX_COUNT[6:0], BUSY}.
// ---------------------------------------------------------------------------
module ir_tx_ctrl
  import ir_tx_pkg::*;
#(
  parameter int         CMD_W           = 4,
  parameter logic [7:0] BASE_ADDR       = 8'h90,
  parameter int         CARRIER_HALF    = 1389,
  parameter int         START_PULSES    = 88,
  parameter int         SEL_PULSES      = 22,
  parameter int         GAP_PULSES      = 40,
  parameter int         ASSERT_PULSES   = 44,
  parameter int         DEASSERT_PULSES = 22,
  parameter int         PERIOD_CYC      = 10_000_000
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             SRC_BUTTONS,
  input  logic [CMD_W-1:0] PUSH_BUTTON,
  input  logic [7:0]       BUS_ADDR,
  input  logic [7:0]       BUS_DATA_IN,
  input  logic             BUS_WE,
  output logic [7:0]       BUS_DATA_OUT,
  output logic             BUS_DATA_OE,
  output logic             IR_LED,
  output logic             BUSY,
  output logic             PKT_DONE
);

  localparam int         TIMER_W     = $clog2(PERIOD_CYC + 1);
  localparam logic [7:0] ADDR_CMD    = BASE_ADDR + REG_CMD;
  localparam logic [7:0] ADDR_CTRL   = BASE_ADDR + REG_CTRL;
  localparam logic [7:0] ADDR_STATUS = BASE_ADDR + REG_STATUS;

  logic [CMD_W-1:0]   cmd_reg;
  logic               auto_en;
  logic [6:0]         tx_count;
  logic [TIMER_W-1:0] rate_cnt;
  logic               rate_tick;
  logic               wr_cmd;
  logic               wr_ctrl;
  logic               oneshot;
  logic               trigger;
  logic               rd_hit;
  logic [7:0]         rd_data;
  logic               unused_bus_bits;

  assign wr_cmd          = BUS_WE && (BUS_ADDR == ADDR_CMD);
  assign wr_ctrl         = BUS_WE && (BUS_ADDR == ADDR_CTRL);
  assign oneshot         = wr_ctrl && BUS_DATA_IN[CTRL_ONESHOT];
  assign rate_tick       = auto_en && (rate_cnt == TIMER_W'(PERIOD_CYC - 1));
  assign trigger         = rate_tick || oneshot;
  assign unused_bus_bits = ^BUS_DATA_IN;

  // Command and control registers. Button mode overrides bus writes to CMD.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      cmd_reg <= '0;
      auto_en <= 1'b0;
    end else begin
      if (SRC_BUTTONS)
        cmd_reg <= PUSH_BUTTON;
      else if (wr_cmd)
        cmd_reg <= BUS_DATA_IN[CMD_W-1:0];
      if (wr_ctrl)
        auto_en <= BUS_DATA_IN[CTRL_AUTO_EN];
    end
  end

  // Rate timer: held at zero while disabled so the first tick lands a full
  // period after enabling.
  always_ff @(posedge CLK) begin
    if (RESET || !auto_en || rate_tick)
      rate_cnt <= '0;
    else
      rate_cnt <= rate_cnt + TIMER_W'(1);
  end

  // Completed packet counter, free-running modulo 128.
  always_ff @(posedge CLK) begin
    if (RESET)
      tx_count <= '0;
    else if (PKT_DONE)
      tx_count <= tx_count + 7'd1;
  end

  // Read mux for the register block; unused bits read as zero.
  always_comb begin
    rd_hit  = 1'b0;
    rd_data = '0;
    if (BUS_ADDR == ADDR_CMD) begin
      rd_hit                = 1'b1;
      rd_data[CMD_W-1:0]    = cmd_reg;
    end else if (BUS_ADDR == ADDR_CTRL) begin
      rd_hit                = 1'b1;
      rd_data[CTRL_AUTO_EN] = auto_en;
    end else if (BUS_ADDR == ADDR_STATUS) begin
      rd_hit                = 1'b1;
      rd_data               = {tx_count, BUSY};
    end
  end

  // Registered read port: data valid for one cycle per read request.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      BUS_DATA_OUT <= '0;
      BUS_DATA_OE  <= 1'b0;
    end else if (!BUS_WE && rd_hit) begin
      BUS_DATA_OUT <= rd_data;
      BUS_DATA_OE  <= 1'b1;
    end else begin
      BUS_DATA_OUT <= '0;
      BUS_DATA_OE  <= 1'b0;
    end
  end

  ir_packet_encoder #(
    .CMD_W           (CMD_W),
    .CARRIER_HALF    (CARRIER_HALF),
    .START_PULSES    (START_PULSES),
    .SEL_PULSES      (SEL_PULSES),
    .GAP_PULSES      (GAP_PULSES),
    .ASSERT_PULSES   (ASSERT_PULSES),
    .DEASSERT_PULSES (DEASSERT_PULSES)
  ) u_encoder (
    .CLK    (CLK),
    .RESET  (RESET),
    .START  (trigger),
    .CMD    (cmd_reg),
    .IR_LED (IR_LED),
    .BUSY   (BUSY),
    .DONE   (PKT_DONE)
  );

endmodule
